// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding controller.
// Exports: sb_entry_t, FWD_SEL_REGFILE, fwd_slot_to_sel().
package hazard_pkg;

    // Widest register address the scoreboard can hold.
    // Narrower addresses are zero-extended into it.
    localparam int SB_RD_W = 5;

    // Scoreboard entry. valid is set only for
    // instructions that actually write rd.
    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    localparam logic [2:0] FWD_SEL_REGFILE = 3'd0;

    // Next-cycle position p maps to select p+1.
    function automatic logic [2:0] fwd_slot_to_sel(
        input logic [1:0] p
    );
        return {1'b0, p} + 3'd1;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-first priority matcher of one source operand against
// the in-flight destinations. Ports: cand (E, S[0]..), src_en,
// src -> hit, p (next-cycle position), is_load of the first match.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int N      = 2,
    parameter int REG_AW = 5
) (
    input  sb_entry_t [N-1:0]    cand,
    input  logic                 src_en,
    input  logic [REG_AW-1:0]    src,
    output logic                 hit,
    output logic [1:0]           p,
    output logic                 is_load
);

    logic [SB_RD_W-1:0] src_x;

    assign src_x = SB_RD_W'(src);

    always_comb begin
        hit     = 1'b0;
        p       = 2'd0;
        is_load = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && src_en && cand[i].valid &&
                cand[i].rd != '0 && cand[i].rd == src_x) begin
                hit     = 1'b1;
                p       = 2'(i);
                is_load = cand[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// RAW bypass select, load-use stall and redirect flush controller.
// Ports: decode fields in, ex_redirect, res_data/regfile in;
// stall/bubble/flush, fwd_sel/fwd_data, saturating counters out.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_SLOT = 1,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic                      dec_rs1_en,
    input  logic                      dec_rs2_en,
    input  logic [REG_AW-1:0]         dec_rs1_addr,
    input  logic [REG_AW-1:0]         dec_rs2_addr,
    input  logic                      dec_rd_en,
    input  logic [REG_AW-1:0]         dec_rd_addr,
    input  logic                      dec_is_load,
    input  logic                      ex_redirect,
    input  logic [FWD_DEPTH*XLEN-1:0] res_data,
    input  logic [XLEN-1:0]           regfile_rs1,
    input  logic [XLEN-1:0]           regfile_rs2,
    output logic                      stall,
    output logic                      bubble,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic [XLEN-1:0]           fwd_data_a,
    output logic [XLEN-1:0]           fwd_data_b,
    output logic [2:0]                fwd_sel_a,
    output logic [2:0]                fwd_sel_b,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          flush_count
);

    sb_entry_t                 e_q;
    sb_entry_t                 e_d;
    sb_entry_t [FWD_DEPTH-1:0] s_q;
    sb_entry_t [FWD_DEPTH-1:0] cand;

    logic       armed_q;
    logic       live;
    logic       issue;
    logic       hit_a, hit_b;
    logic       ld_a, ld_b;
    logic [1:0] p_a, p_b;
    logic       lu_a, lu_b;

    // The oldest slot is excluded: its value has
    // already reached the write-first register file.
    always_comb begin
        cand[0] = e_q;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            cand[k] = s_q[k-1];
        end
    end

    hazard_src_match #(
        .N      (FWD_DEPTH),
        .REG_AW (REG_AW)
    ) u_match_a (
        .cand    (cand),
        .src_en  (dec_rs1_en),
        .src     (dec_rs1_addr),
        .hit     (hit_a),
        .p       (p_a),
        .is_load (ld_a)
    );

    hazard_src_match #(
        .N      (FWD_DEPTH),
        .REG_AW (REG_AW)
    ) u_match_b (
        .cand    (cand),
        .src_en  (dec_rs2_en),
        .src     (dec_rs2_addr),
        .hit     (hit_b),
        .p       (p_b),
        .is_load (ld_b)
    );

    // Only the youngest match counts, so a stall is
    // decided by that match alone.
    assign lu_a = hit_a && ld_a && ({1'b0, p_a} < 3'(LOAD_SLOT));
    assign lu_b = hit_b && ld_b && ({1'b0, p_b} < 3'(LOAD_SLOT));

    // Controls stay quiet during reset and the first
    // cycle after release.
    assign live        = armed_q && !reset;
    assign stall       = live && dec_valid && !ex_redirect &&
                         (lu_a || lu_b);
    assign bubble      = stall;
    assign flush_if_id = live && ex_redirect;
    assign flush_id_ex = live && ex_redirect;

    assign issue = dec_valid && !stall && !ex_redirect;

    always_comb begin
        e_d         = '0;
        e_d.valid   = issue && dec_rd_en;
        e_d.rd      = SB_RD_W'(dec_rd_addr);
        e_d.is_load = dec_is_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            s_q         <= '0;
            armed_q     <= 1'b0;
            fwd_sel_a   <= FWD_SEL_REGFILE;
            fwd_sel_b   <= FWD_SEL_REGFILE;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            e_q     <= e_d;
            s_q[0]  <= e_q;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                s_q[k] <= s_q[k-1];
            end
            armed_q <= 1'b1;

            fwd_sel_a <= (issue && hit_a) ? fwd_slot_to_sel(p_a)
                                          : FWD_SEL_REGFILE;
            fwd_sel_b <= (issue && hit_b) ? fwd_slot_to_sel(p_b)
                                          : FWD_SEL_REGFILE;

            if (stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_if_id && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    always_comb begin
        fwd_data_a = regfile_rs1;
        fwd_data_b = regfile_rs2;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (fwd_sel_a == 3'(k + 1)) begin
                fwd_data_a = res_data[k*XLEN +: XLEN];
            end
            if (fwd_sel_b == 3'(k + 1)) begin
                fwd_data_b = res_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios
// with literal expectations plus randomized traffic vs. a model.
module tb_hazard_forward_unit;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int FD   = 2;
    localparam int LS   = 1;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk;
    logic                 reset;
    logic                 dec_valid;
    logic                 dec_rs1_en, dec_rs2_en;
    logic [RAW-1:0]       dec_rs1_addr, dec_rs2_addr;
    logic                 dec_rd_en;
    logic [RAW-1:0]       dec_rd_addr;
    logic                 dec_is_load;
    logic                 ex_redirect;
    logic [FD*XLEN-1:0]   res_data;
    logic [XLEN-1:0]      regfile_rs1, regfile_rs2;
    logic                 stall, bubble;
    logic                 flush_if_id, flush_id_ex;
    logic [XLEN-1:0]      fwd_data_a, fwd_data_b;
    logic [2:0]           fwd_sel_a, fwd_sel_b;
    logic [CW-1:0]        stall_count, flush_count;

    hazard_forward_unit #(
        .XLEN      (XLEN),
        .REG_AW    (RAW),
        .FWD_DEPTH (FD),
        .LOAD_SLOT (LS),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1_en   (dec_rs1_en),
        .dec_rs2_en   (dec_rs2_en),
        .dec_rs1_addr (dec_rs1_addr),
        .dec_rs2_addr (dec_rs2_addr),
        .dec_rd_en    (dec_rd_en),
        .dec_rd_addr  (dec_rd_addr),
        .dec_is_load  (dec_is_load),
        .ex_redirect  (ex_redirect),
        .res_data     (res_data),
        .regfile_rs1  (regfile_rs1),
        .regfile_rs2  (regfile_rs2),
        .stall        (stall),
        .bubble       (bubble),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .fwd_data_a   (fwd_data_a),
        .fwd_data_b   (fwd_data_b),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: history of issued instructions, age 0 = youngest.
    bit         h_iss [4];
    bit         h_wen [4];
    bit         h_ld  [4];
    logic [4:0] h_rd  [4];
    int         m_sel_a, m_sel_b, m_sc, m_fc;
    bit         m_armed;

    // Age a will sit in result slot a next cycle; only ages
    // below FD are still bypassable.
    function automatic void find(input logic en, input logic [4:0] src,
                                 output bit hit, output int p,
                                 output bit ld);
        hit = 0; p = 0; ld = 0;
        if (en && src != 0) begin
            for (int a = 0; a < FD; a++) begin
                if (!hit && h_iss[a] && h_wen[a] && h_rd[a] == src) begin
                    hit = 1; p = a; ld = h_ld[a];
                end
            end
        end
    endfunction

    function automatic bit exp_stall();
        bit ha, hb, la, lb;
        int pa, pb;
        find(dec_rs1_en, dec_rs1_addr, ha, pa, la);
        find(dec_rs2_en, dec_rs2_addr, hb, pb, lb);
        return m_armed && !reset && dec_valid && !ex_redirect &&
               ((ha && la && pa < LS) || (hb && lb && pb < LS));
    endfunction

    function automatic logic [31:0] exp_data(input int sel,
                                             input logic [31:0] rf);
        if (sel == 0) return rf;
        return res_data[(sel-1)*XLEN +: XLEN];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 4; a++) begin
                h_iss[a] = 0; h_wen[a] = 0; h_ld[a] = 0; h_rd[a] = 0;
            end
            m_sel_a = 0; m_sel_b = 0; m_sc = 0; m_fc = 0;
            m_armed = 0;
        end else begin
            bit ha, hb, la, lb, st, iss;
            int pa, pb;
            find(dec_rs1_en, dec_rs1_addr, ha, pa, la);
            find(dec_rs2_en, dec_rs2_addr, hb, pb, lb);
            st  = exp_stall();
            iss = dec_valid && !st && !ex_redirect;
            if (st && m_sc < CMAX) m_sc++;
            if (m_armed && ex_redirect && m_fc < CMAX) m_fc++;
            m_sel_a = (iss && ha) ? pa + 1 : 0;
            m_sel_b = (iss && hb) ? pb + 1 : 0;
            for (int a = 3; a > 0; a--) begin
                h_iss[a] = h_iss[a-1]; h_wen[a] = h_wen[a-1];
                h_ld[a]  = h_ld[a-1];  h_rd[a]  = h_rd[a-1];
            end
            h_iss[0] = iss;
            h_wen[0] = dec_rd_en;
            h_ld[0]  = dec_is_load;
            h_rd[0]  = dec_rd_addr;
            m_armed  = 1;
        end
    end

    always @(negedge clk) begin
        bit es, ef;
        es = exp_stall();
        ef = m_armed && !reset && ex_redirect;
        chk("m_stall", 32'(stall), 32'(es));
        chk("m_bubble", 32'(bubble), 32'(es));
        chk("m_flush_if_id", 32'(flush_if_id), 32'(ef));
        chk("m_flush_id_ex", 32'(flush_id_ex), 32'(ef));
        chk("m_sel_a", 32'(fwd_sel_a), 32'(m_sel_a));
        chk("m_sel_b", 32'(fwd_sel_b), 32'(m_sel_b));
        chk("m_data_a", fwd_data_a, exp_data(m_sel_a, regfile_rs1));
        chk("m_data_b", fwd_data_b, exp_data(m_sel_b, regfile_rs2));
        chk("m_stall_count", 32'(stall_count), 32'(m_sc));
        chk("m_flush_count", 32'(flush_count), 32'(m_fc));
    end

    task automatic nop();
        dec_valid = 0; dec_rs1_en = 0; dec_rs2_en = 0;
        dec_rs1_addr = 0; dec_rs2_addr = 0;
        dec_rd_en = 0; dec_rd_addr = 0; dec_is_load = 0;
        ex_redirect = 0;
    endtask

    task automatic ins(input bit e1, input int r1, input bit e2,
                       input int r2, input bit we, input int rd,
                       input bit ld);
        dec_valid = 1;
        dec_rs1_en = e1; dec_rs1_addr = 5'(r1);
        dec_rs2_en = e2; dec_rs2_addr = 5'(r2);
        dec_rd_en = we;  dec_rd_addr = 5'(rd);
        dec_is_load = ld; ex_redirect = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RF1 = 32'hAAAA_0001;
    localparam logic [31:0] RF2 = 32'hBBBB_0002;
    localparam logic [31:0] SL0 = 32'h0000_0007;
    localparam logic [31:0] SL1 = 32'h1111_1111;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        nop();
        res_data = {SL1, SL0};
        regfile_rs1 = RF1;
        regfile_rs2 = RF2;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel_a", 32'(fwd_sel_a), 0);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_flush_count", 32'(flush_count), 0);
        step();
        reset = 0;
        step();
        step();

        // ALU chain back-to-back
        ins(1, 0, 0, 0, 1, 5, 0); step();
        ins(1, 5, 1, 5, 1, 6, 0);
        @(negedge clk); chk("alu_nostall", 32'(stall), 0); step();
        nop();
        @(negedge clk);
        chk("alu_sel_a", 32'(fwd_sel_a), 1);
        chk("alu_sel_b", 32'(fwd_sel_b), 1);
        chk("alu_data_a", fwd_data_a, 32'h0000_0007);
        step(); step();

        // distance 2
        ins(1, 0, 0, 0, 1, 5, 0); step();
        ins(1, 1, 1, 2, 1, 9, 0); step();
        ins(1, 5, 0, 0, 1, 10, 0); step();
        nop();
        @(negedge clk);
        chk("d2_sel_a", 32'(fwd_sel_a), 2);
        chk("d2_data_a", fwd_data_a, SL1);
        step(); step();

        // distance 3
        ins(1, 0, 0, 0, 1, 5, 0); step();
        ins(1, 1, 1, 2, 1, 9, 0); step();
        ins(1, 1, 1, 2, 1, 9, 0); step();
        ins(1, 5, 0, 0, 1, 10, 0); step();
        nop();
        @(negedge clk);
        chk("d3_sel_a", 32'(fwd_sel_a), 0);
        chk("d3_data_a", fwd_data_a, RF1);
        step(); step();

        // load-use
        ins(0, 0, 0, 0, 1, 7, 1); step();
        ins(1, 7, 1, 0, 1, 8, 0);
        @(negedge clk);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        step();
        @(negedge clk); chk("lu_stall_clear", 32'(stall), 0); step();
        nop();
        @(negedge clk);
        chk("lu_sel_a", 32'(fwd_sel_a), 2);
        chk("lu_sel_b", 32'(fwd_sel_b), 0);
        chk("lu_data_a", fwd_data_a, SL1);
        chk("lu_stall_count", 32'(stall_count), 1);
        step(); step();

        // youngest producer wins
        ins(1, 0, 0, 0, 1, 5, 0); step();
        ins(1, 0, 0, 0, 1, 5, 0); step();
        ins(1, 5, 0, 0, 1, 12, 0); step();
        nop();
        res_data[31:0] = 32'h0000_0002;
        @(negedge clk);
        chk("yw_sel_a", 32'(fwd_sel_a), 1);
        chk("yw_data_a", fwd_data_a, 32'h0000_0002);
        step();
        res_data[31:0] = SL0;
        step();

        // x0 never forwarded
        ins(0, 0, 0, 0, 1, 0, 0); step();
        ins(1, 0, 0, 0, 1, 11, 0); step();
        nop();
        @(negedge clk); chk("x0_sel_a", 32'(fwd_sel_a), 0);
        step(); step();

        // redirect during load-use
        ins(0, 0, 0, 0, 1, 7, 1); step();
        ins(1, 7, 0, 0, 1, 8, 0);
        ex_redirect = 1;
        @(negedge clk);
        chk("rd_flush_if_id", 32'(flush_if_id), 1);
        chk("rd_flush_id_ex", 32'(flush_id_ex), 1);
        chk("rd_stall", 32'(stall), 0);
        chk("rd_bubble", 32'(bubble), 0);
        step();
        nop();
        @(negedge clk);
        chk("rd_flush_count", 32'(flush_count), 1);
        chk("rd_stall_count", 32'(stall_count), 1);
        step(); step();

        // async reset mid-stall
        ins(0, 0, 0, 0, 1, 7, 1); step();
        ins(1, 7, 0, 0, 1, 8, 0);
        @(negedge clk); chk("ar_stall_pre", 32'(stall), 1);
        #2 reset = 1;
        #1;
        chk("ar_stall", 32'(stall), 0);
        chk("ar_bubble", 32'(bubble), 0);
        chk("ar_sel_a", 32'(fwd_sel_a), 0);
        chk("ar_stall_count", 32'(stall_count), 0);
        chk("ar_flush_count", 32'(flush_count), 0);
        step();
        reset = 0;
        nop();
        step();
        ins(1, 3, 0, 0, 1, 4, 0); step();
        nop();
        @(negedge clk); chk("ar_post_sel_a", 32'(fwd_sel_a), 0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            dec_valid    = ($urandom_range(0, 9) < 8);
            dec_rs1_en   = $urandom_range(0, 3) != 0;
            dec_rs2_en   = $urandom_range(0, 1) != 0;
            dec_rs1_addr = 5'($urandom_range(0, 7));
            dec_rs2_addr = 5'($urandom_range(0, 7));
            dec_rd_en    = $urandom_range(0, 3) != 0;
            dec_rd_addr  = 5'($urandom_range(0, 7));
            dec_is_load  = $urandom_range(0, 9) < 3;
            ex_redirect  = $urandom_range(0, 19) == 0;
            res_data     = {$urandom, $urandom};
            regfile_rs1  = $urandom;
            regfile_rs2  = $urandom;
            step();
        end
        nop();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
